// File: rtl/line_draw_ctrl.sv
// line_draw_ctrl: round-robin sequencer in front of a Bresenham line drawer.
// Grants one client line at a time, loads its endpoints into the drawer,
// turns the drawer's per-cycle point into framebuffer writes for exactly
// max(|dx|,|dy|)+1 cycles, and runs a full-screen raster clear on demand.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   req[NUM_REQ]        level line request per client
//   line_in             client i at [i*4*COORD_W +: 4*COORD_W] = {x0,y0,x1,y1}
//   colour_in[NUM_REQ]  per-client pixel colour
//   clear_req           level request for a full-screen clear (colour 0)
//   grant, done         one-hot single-cycle ack / completion per client
//   clear_done          single-cycle pulse when the clear sweep finishes
//   busy                high whenever the sequencer is not idle
//   ld_x0..ld_y1, ld_load  endpoints and load strobe to the drawer
//   ld_x, ld_y          current drawer point
//   pix_x, pix_y, pix_colour, pix_we  framebuffer write port
module line_draw_ctrl #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned COORD_W  = 11,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*4*COORD_W-1:0] line_in,
  input  logic [NUM_REQ-1:0]           colour_in,
  input  logic                         clear_req,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         clear_done,
  output logic                         busy,
  output logic [COORD_W-1:0]           ld_x0,
  output logic [COORD_W-1:0]           ld_y0,
  output logic [COORD_W-1:0]           ld_x1,
  output logic [COORD_W-1:0]           ld_y1,
  output logic                         ld_load,
  input  logic [COORD_W-1:0]           ld_x,
  input  logic [COORD_W-1:0]           ld_y,
  output logic [COORD_W-1:0]           pix_x,
  output logic [COORD_W-1:0]           pix_y,
  output logic                         pix_colour,
  output logic                         pix_we
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned LINE_W = 4 * COORD_W;
  localparam int unsigned CNT_W  = COORD_W + 1;

  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
  } line_t;

  typedef enum logic [2:0] {IDLE, LOAD, DRAW, DONE, CLEAR} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   last_grant_q, cur_idx_q, sel_idx, cand;
  logic               any_req;
  logic               colour_q;
  logic [COORD_W-1:0] pix_x_q, pix_y_q;
  line_t              sel_line;
  logic [COORD_W-1:0] dx, dy;
  logic [CNT_W-1:0]   len_cnt;
  logic               clr_last;

  logic [NUM_REQ-1:0] grant_d, done_d;
  logic               clear_done_d, busy_d, ld_load_d, pix_we_d, pix_colour_d;

  // Round-robin pick: first requester at or after last_grant+1
  always_comb begin
    any_req = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_grant_q) + 32'd1 + k) % NUM_REQ);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        sel_idx = cand;
      end
    end
  end

  assign sel_line = line_t'(line_in[32'(sel_idx)*LINE_W +: LINE_W]);

  // Pixel count = major-axis span + 1; direction independent
  always_comb begin
    dx = (sel_line.x1 >= sel_line.x0) ? sel_line.x1 - sel_line.x0 : sel_line.x0 - sel_line.x1;
    dy = (sel_line.y1 >= sel_line.y0) ? sel_line.y1 - sel_line.y0 : sel_line.y0 - sel_line.y1;
    len_cnt = CNT_W'((dx >= dy) ? dx : dy) + CNT_W'(1);
  end

  assign clr_last = (pix_x_q == COORD_W'(SCREEN_W - 1)) && (pix_y_q == COORD_W'(SCREEN_H - 1));

  // Next state and next registered outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = '0;
    done_d       = '0;
    clear_done_d = 1'b0;
    busy_d       = 1'b0;
    ld_load_d    = 1'b0;
    pix_we_d     = 1'b0;
    pix_colour_d = pix_colour;

    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
        end else if (any_req) begin
          state_d = LOAD;
          cnt_d   = len_cnt;
        end
      end
      LOAD:  state_d = DRAW;
      DRAW: begin
        if (cnt_q == CNT_W'(1)) state_d = DONE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE:  state_d = IDLE;
      CLEAR: if (clr_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE && state_d == LOAD) grant_d = NUM_REQ'(1) << sel_idx;
    if (state_d == DONE)                    done_d  = NUM_REQ'(1) << cur_idx_q;
    clear_done_d = (state_q == CLEAR) && (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    ld_load_d    = (state_d == LOAD);
    pix_we_d     = (state_d == DRAW) || (state_d == CLEAR);
    if (state_d == DRAW)  pix_colour_d = colour_q;
    if (state_d == CLEAR) pix_colour_d = 1'b0;
  end

  // State, latched request and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      cur_idx_q    <= '0;
      colour_q     <= 1'b0;
      ld_x0        <= '0;
      ld_y0        <= '0;
      ld_x1        <= '0;
      ld_y1        <= '0;
      grant        <= '0;
      done         <= '0;
      clear_done   <= 1'b0;
      busy         <= 1'b0;
      ld_load      <= 1'b0;
      pix_we       <= 1'b0;
      pix_colour   <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant      <= grant_d;
      done       <= done_d;
      clear_done <= clear_done_d;
      busy       <= busy_d;
      ld_load    <= ld_load_d;
      pix_we     <= pix_we_d;
      pix_colour <= pix_colour_d;

      if (state_q == IDLE && state_d == LOAD) begin
        ld_x0     <= sel_line.x0;
        ld_y0     <= sel_line.y0;
        ld_x1     <= sel_line.x1;
        ld_y1     <= sel_line.y1;
        colour_q  <= colour_in[sel_idx];
        cur_idx_q <= sel_idx;
      end
      if (state_q == DONE) last_grant_q <= cur_idx_q;

      // Address register doubles as the raster counter and the hold value
      if (state_q == IDLE && state_d == CLEAR) begin
        pix_x_q <= '0;
        pix_y_q <= '0;
      end else if (state_q == CLEAR && !clr_last) begin
        if (pix_x_q == COORD_W'(SCREEN_W - 1)) begin
          pix_x_q <= '0;
          pix_y_q <= pix_y_q + COORD_W'(1);
        end else begin
          pix_x_q <= pix_x_q + COORD_W'(1);
        end
      end else if (state_q == DRAW) begin
        pix_x_q <= ld_x;
        pix_y_q <= ld_y;
      end
    end
  end

  // Drawer point passes straight through while drawing; otherwise hold/raster
  assign pix_x = (state_q == DRAW) ? ld_x : pix_x_q;
  assign pix_y = (state_q == DRAW) ? ld_y : pix_y_q;

endmodule

// File: tb/tb_line_draw_ctrl.sv
// tb_line_draw_ctrl: directed bench for line_draw_ctrl with a stepping drawer stub.
module tb_line_draw_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = '0;
  logic [87:0] line_in = '0;
  logic [1:0]  colour_in = '0;
  logic        clear_req = 1'b0;
  logic [1:0]  grant, done;
  logic        clear_done, busy, ld_load, pix_colour, pix_we;
  logic [10:0] ld_x0, ld_y0, ld_x1, ld_y1, ld_x, ld_y, pix_x, pix_y;

  line_draw_ctrl #(.NUM_REQ(2), .COORD_W(11), .SCREEN_W(8), .SCREEN_H(4)) dut (
    .clk(clk), .reset(reset), .req(req), .line_in(line_in), .colour_in(colour_in),
    .clear_req(clear_req), .grant(grant), .done(done), .clear_done(clear_done),
    .busy(busy), .ld_x0(ld_x0), .ld_y0(ld_y0), .ld_x1(ld_x1), .ld_y1(ld_y1),
    .ld_load(ld_load), .ld_x(ld_x), .ld_y(ld_y), .pix_x(pix_x), .pix_y(pix_y),
    .pix_colour(pix_colour), .pix_we(pix_we)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Drawer stub: start point the cycle after load, then one step toward the end
  logic [10:0] sx = '0, sy = '0;
  always @(posedge clk) begin
    if (ld_load) begin
      sx <= ld_x0;
      sy <= ld_y0;
    end else begin
      if (sx < ld_x1) sx <= sx + 11'd1; else if (sx > ld_x1) sx <= sx - 11'd1;
      if (sy < ld_y1) sy <= sy + 11'd1; else if (sy > ld_y1) sy <= sy - 11'd1;
    end
  end
  assign ld_x = sx;
  assign ld_y = sy;

  // Write / pulse monitor
  int          wx[$], wy[$], wcyc[$];
  logic        wc[$];
  int          dn0 = 0, dn1 = 0, ncd = 0;
  always @(negedge clk) begin
    if (pix_we) begin
      wx.push_back(int'(pix_x));
      wy.push_back(int'(pix_y));
      wc.push_back(pix_colour);
      wcyc.push_back(cyc);
    end
    if (done[0]) dn0++;
    if (done[1]) dn1++;
    if (clear_done) ncd++;
  end

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wx.delete(); wy.delete(); wc.delete(); wcyc.delete();
  endtask

  task automatic set_line(input int idx, input int x0, input int y0, input int x1, input int y1);
    line_in[idx*44 +: 44] = {11'(x0), 11'(y0), 11'(x1), 11'(y1)};
  endtask

  task automatic wait_grant(input string tag, output int gc, output logic [1:0] gv);
    gc = -1; gv = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (grant != 2'b00) begin gc = cyc; gv = grant; return; end
    end
    check({tag, "_grant_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string tag, output int dc, output logic [1:0] dv);
    dc = -1; dv = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done != 2'b00) begin dc = cyc; dv = done; return; end
    end
    check({tag, "_done_timeout"}, 0, 1);
  endtask

  // One line transaction; req dropped once granted
  task automatic run_line(input string tag, input int idx, input int x0, input int y0,
                          input int x1, input int y1, input logic col,
                          output int t0, output int gc, output logic [1:0] gv,
                          output int dc, output logic [1:0] dv);
    @(negedge clk);
    clear_log();
    set_line(idx, x0, y0, x1, y1);
    colour_in[idx] = col;
    req[idx] = 1'b1;
    t0 = cyc;
    wait_grant(tag, gc, gv);
    req[idx] = 1'b0;
    wait_done(tag, dc, dv);
    @(negedge clk);
  endtask

  int t0, gc, dc, bad, d0s, d1s, cds, cdc, n;
  logic [1:0] gv, dv;
  logic [1:0] gseq[4];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_outputs", {grant, done, clear_done, busy, ld_load, pix_we, pix_colour,
                            pix_x, pix_y, ld_x0}, 64'd0);

    // Horizontal line, client 0
    d0s = dn0;
    run_line("t1", 0, 10, 100, 25, 100, 1'b1, t0, gc, gv, dc, dv);
    check("t1_grant_cyc", gc, t0 + 1);
    check("t1_grant_val", gv, 2'b01);
    check("t1_writes", wx.size(), 16);
    check("t1_first_we_cyc", (wcyc.size() > 0) ? wcyc[0] : -1, t0 + 2);
    bad = 0;
    foreach (wx[i]) if (wx[i] != 10 + i || wy[i] != 100 || wc[i] !== 1'b1) bad++;
    check("t1_path", bad, 0);
    check("t1_done_cyc", dc, t0 + 18);
    check("t1_done_val", dv, 2'b01);
    check("t1_done_pulses", dn0 - d0s, 1);

    // Zero-length line, client 0
    run_line("t6", 0, 5, 5, 5, 5, 1'b1, t0, gc, gv, dc, dv);
    check("t6_writes", wx.size(), 1);
    check("t6_point", (wx.size() > 0) ? {wx[0], wy[0]} : 64'hffff, {32'd5, 32'd5});
    check("t6_done_cyc", dc, t0 + 3);

    // Reverse diagonal, client 1, colour 0
    d1s = dn1;
    run_line("t2", 1, 200, 200, 190, 190, 1'b0, t0, gc, gv, dc, dv);
    check("t2_grant_val", gv, 2'b10);
    check("t2_writes", wx.size(), 11);
    bad = 0;
    foreach (wx[i]) if (wx[i] != 200 - i || wy[i] != 200 - i || wc[i] !== 1'b0) bad++;
    check("t2_path", bad, 0);
    check("t2_done_cyc", dc, t0 + 13);
    check("t2_done_pulses", dn1 - d1s, 1);

    // Both clients held: strict alternation starting at 0
    @(negedge clk);
    set_line(0, 0, 0, 1, 0);
    set_line(1, 3, 3, 3, 4);
    colour_in = 2'b11;
    req = 2'b11;
    n = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge clk);
      if (grant != 2'b00) begin
        gseq[n] = grant;
        n++;
        if (n == 4) req = 2'b00;
      end
    end
    check("t3_grant_count", n, 4);
    check("t3_seq", {gseq[0], gseq[1], gseq[2], gseq[3]}, 8'b01_10_01_10);
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    check("t3_idle", busy, 1'b0);

    // Clear and line request in the same cycle: clear wins, line follows
    @(negedge clk);
    clear_log();
    cds = ncd;
    set_line(0, 1, 1, 2, 1);
    colour_in[0] = 1'b1;
    req = 2'b01;
    clear_req = 1'b1;
    t0 = cyc;
    @(negedge clk);
    check("t4_clear_first", {busy, grant, pix_we}, {1'b1, 2'b00, 1'b1});
    clear_req = 1'b0;
    cdc = -1;
    for (int i = 0; i < 100; i++) begin
      if (clear_done) begin cdc = cyc; break; end
      @(negedge clk);
    end
    check("t4_clear_done_cyc", cdc, t0 + 33);
    check("t4_writes", wx.size(), 32);
    bad = 0;
    foreach (wx[i]) if (wx[i] != i % 8 || wy[i] != i / 8 || wc[i] !== 1'b0) bad++;
    check("t4_raster", bad, 0);
    check("t4_hold_addr", {pix_we, pix_x, pix_y}, {1'b0, 11'd7, 11'd3});
    wait_grant("t4", gc, gv);
    req = 2'b00;
    check("t4_grant_cyc", gc, t0 + 34);
    check("t4_grant_val", gv, 2'b01);
    wait_done("t4", dc, dv);
    @(negedge clk);
    check("t4_clear_pulses", ncd - cds, 1);

    // Asynchronous reset in the middle of a long line from client 1
    @(negedge clk);
    set_line(1, 0, 0, 50, 0);
    colour_in[1] = 1'b1;
    req = 2'b10;
    wait_grant("t5", gc, gv);
    req = 2'b00;
    repeat (3) @(negedge clk);
    check("t5_in_draw", {pix_we, busy}, 2'b11);
    d1s = dn1;
    #2 reset = 1'b1;
    #1 check("t5_async_clear", {grant, done, clear_done, busy, ld_load, pix_we, pix_colour,
                                pix_x, pix_y, ld_x1}, 64'd0);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_no_done", dn1 - d1s, 0);
    set_line(0, 7, 7, 8, 8);
    set_line(1, 9, 9, 9, 9);
    req = 2'b11;
    wait_grant("t5b", gc, gv);
    req = 2'b00;
    check("t5_grant_after_reset", gv, 2'b01);
    wait_done("t5b", dc, dv);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
